pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//   Control unit for the 5-stage 8-bit pipeline (IF/ID/EX/MEM/WB). Tracks in-flight destination
//   registers, selects operand forwarding for ID->EX, inserts load-use bubbles, and drains and
//   halts the pipe on request. Drives the IF/ID enables and the ID/EX bubble; owns no datapath.
// PARAMETERS
//   RA_W   2   register-address width (4-entry register file)
// PORTS
//   clk          in   1     clock
//   reset        in   1     asynchronous, active-high reset
//   id_valid     in   1     IF/ID holds a valid instruction
//   id_rs1       in   RA_W  source 1 address
//   id_rs1_used  in   1     source 1 is read
//   id_rs2       in   RA_W  source 2 address
//   id_rs2_used  in   1     source 2 is read
//   id_rd        in   RA_W  destination address
//   id_rd_we     in   1     instruction writes id_rd
//   id_is_load   in   1     instruction is LOAD (result valid only after MEM)
//   halt_req     in   1     level: drain and hold pipe while high
//   pc_en        out  1     advance PC
//   ifid_en      out  1     load IF/ID register
//   idex_bubble  out  1     load NOP into ID/EX
//   issue        out  1     ID instruction moves to EX this cycle
//   fwd_sel_a    out  2     source 1 mux: 0 RF, 1 EX result, 2 MEM result, 3 WB result
//   fwd_sel_b    out  2     source 2 mux, same encoding
//   halted       out  1     pipe empty and held
//   stall_cnt    out  16    load-use stall cycles (see CONFIGURATION)
// BEHAVIOUR
//   - Tracker: entries ex_q, mem_q, wb_q = {vld, rd, we, ld}. Every cycle wb_q<=mem_q, mem_q<=ex_q,
//     ex_q<={issue, id_rd, id_rd_we, id_is_load}. Bubbles enter as vld=0.
//   - match_X(rs) = X.vld & X.we & X.rd==rs. No hardwired-zero register.
//   - hazard = id_valid & ex_q.ld & ((rs1_used & match_ex(rs1)) | (rs2_used & match_ex(rs2))).
//   - fwd_sel per source: rs_used=0 -> 0; else youngest match wins: EX=1, MEM=2, WB=3, none=0.
//     Load in MEM is forwarded from MEM (sel 2); a load in EX is never forwarded.
//   - FSM RUN/DRAIN/HALTED, reset state RUN.
//     RUN: halt_req -> DRAIN; else stay.
//     DRAIN: ex_q,mem_q,wb_q all vld=0 -> HALTED.
//     HALTED: !halt_req -> RUN.
//   - Outputs (combinational from state, tracker, ID inputs):
//     go = (state==RUN) & !halt_req & !hazard
//     pc_en = ifid_en = go; issue = go & id_valid; idex_bubble = !issue; halted = (state==HALTED).
//   - Load-use: exactly 1 bubble; next cycle the load is in MEM, hazard clears, fwd_sel=2.
//   - halt_req wins over hazard in the same cycle. Held IF/ID instruction is not lost; it issues
//     on the first RUN cycle after resume. halt_req dropped during DRAIN: finish drain, enter
//     HALTED, exit to RUN the next cycle.
//   - Drain takes up to 3 cycles; halted=1 on the cycle after the last entry leaves WB.
//   - Reset (any time, incl. mid-drain): state RUN, all entries vld=0, stall_cnt=0. While reset
//     is high: pc_en=0, ifid_en=0, issue=0, idex_bubble=1, fwd_sel_a/b=0, halted=0.
// CONFIGURATION
//   HAZ_PERF_CNT_EN defined: stall_cnt += 1 on each cycle hazard & state==RUN & !halt_req;
//     saturates at 16'hFFFF.
//   Undefined: no counter logic; stall_cnt tied to 16'd0.
// STRUCTURE
//   pipe_ctrl_pkg: FWD_RF/FWD_EX/FWD_MEM/FWD_WB constants, ctrl_state_t enum (RUN/DRAIN/HALTED),
//     inflight_t struct {vld, rd, we, ld}.
//   One sub-module: pipe_inflight_track (3-entry tracker shift register plus match outputs).
//   FSM, hazard logic, forwarding priority and counter stay in the top.
// TESTING
//   1 reset=1 -> pc_en=0, idex_bubble=1, fwd_sel=0; release, id_valid=0 -> pc_en=1, issue=0,
//     halted=0.
//   2 ADD rd=1, then SUB rs1=1 -> sel_a=1; SUB held 3 more cycles -> sel_a=2, 3, then 0;
//     no stall, stall_cnt=0.
//   3 LOAD rd=1, then ADD rs2=1 -> 1 cycle pc_en=0, idex_bubble=1; next cycle issue=1,
//     sel_b=2; stall_cnt=1 (0 without macro).
//   4 rd=2 in EX and MEM, rd=3 in WB; ID rs1=2, rs2=3 -> sel_a=1, sel_b=3; repeat with
//     rs1_used=0 -> sel_a=0; repeat with EX entry we=0 -> sel_a=2.
//   5 three issued instrs, halt_req=1 -> pc_en=0 at once; halted=1 4 cycles later;
//     halt_req=0 -> RUN next cycle, held instr issues.
//   6 reset pulse mid-DRAIN with 2 entries vld -> RUN, tracker empty, stall_cnt=0, fwd_sel=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the 5-stage pipeline hazard controller:
// forwarding-mux codes, control FSM states and the in-flight tracker entry.
package pipe_ctrl_pkg;

    localparam int REG_AW      = 2;
    localparam int TRACK_DEPTH = 3;
    localparam int STG_EX      = 0;
    localparam int STG_MEM     = 1;
    localparam int STG_WB      = 2;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    // A load's data exists only once it has passed EX.
    localparam logic [TRACK_DEPTH-1:0] LD_READY = 3'b110;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    typedef struct packed {
        logic              vld;
        logic [REG_AW-1:0] rd;
        logic              we;
        logic              ld;
    } inflight_t;

    localparam inflight_t INFLIGHT_EMPTY = '0;

    // Youngest matching stage wins; a match on a not-yet-ready load reads the RF.
    function automatic logic [1:0] fwd_pick(input logic used,
                                            input logic [TRACK_DEPTH-1:0] hit,
                                            input logic [TRACK_DEPTH-1:0] pend);
        logic [1:0] sel;
        logic       found;
        sel   = FWD_RF;
        found = 1'b0;
        for (int i = 0; i < TRACK_DEPTH; i++) begin
            if (used && !found && hit[i]) begin
                found = 1'b1;
                sel   = pend[i] ? FWD_RF : 2'(i + 1);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage request and pipeline-control response bundle between the
// pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if #(
    parameter int RA_W = 2
);
    logic            id_valid;
    logic [RA_W-1:0] id_rs1;
    logic            id_rs1_used;
    logic [RA_W-1:0] id_rs2;
    logic            id_rs2_used;
    logic [RA_W-1:0] id_rd;
    logic            id_rd_we;
    logic            id_is_load;
    logic            halt_req;

    logic            pc_en;
    logic            ifid_en;
    logic            idex_bubble;
    logic            issue;
    logic [1:0]      fwd_sel_a;
    logic [1:0]      fwd_sel_b;
    logic            halted;
    logic [15:0]     stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_rd, id_rd_we, id_is_load, halt_req,
        input  pc_en, ifid_en, idex_bubble, issue, fwd_sel_a, fwd_sel_b,
               halted, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs1_used, id_rs2, id_rs2_used,
               id_rd, id_rd_we, id_is_load, halt_req,
        output pc_en, ifid_en, idex_bubble, issue, fwd_sel_a, fwd_sel_b,
               halted, stall_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctrl_inflight_track.sv
// Three-entry EX/MEM/WB shift register of in-flight destinations, with
// per-stage source-match and load-not-ready flags.
module pipe_inflight_track
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W = REG_AW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  inflight_t              ins_i,
    input  logic [RA_W-1:0]        rs1_i,
    input  logic [RA_W-1:0]        rs2_i,
    output logic [TRACK_DEPTH-1:0] hit1_o,
    output logic [TRACK_DEPTH-1:0] hit2_o,
    output logic [TRACK_DEPTH-1:0] pend_o,
    output logic                   busy_o
);

    inflight_t                stage_q [TRACK_DEPTH];
    inflight_t                stage_d [TRACK_DEPTH];
    logic [TRACK_DEPTH-1:0]   vld_vec;

    genvar gi;
    generate
        for (gi = 0; gi < TRACK_DEPTH; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign stage_d[gi] = ins_i;
            end else begin : g_shift
                assign stage_d[gi] = stage_q[gi-1];
            end

            assign vld_vec[gi] = stage_q[gi].vld;
            assign hit1_o[gi]  = stage_q[gi].vld & stage_q[gi].we & (stage_q[gi].rd == rs1_i);
            assign hit2_o[gi]  = stage_q[gi].vld & stage_q[gi].we & (stage_q[gi].rd == rs2_i);
            assign pend_o[gi]  = stage_q[gi].vld & stage_q[gi].ld & ~LD_READY[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TRACK_DEPTH; i++) begin
                stage_q[i] <= INFLIGHT_EMPTY;
            end
        end else begin
            for (int i = 0; i < TRACK_DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign busy_o = |vld_vec;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/forwarding/halt controller for the 5-stage 8-bit pipeline.
// Optional load-use stall counter enabled by defining HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int RA_W = REG_AW
) (
    input logic               clk,
    input logic               reset,
    pipe_hazard_ctrl_if.slave bus
);

    ctrl_state_t            state_q, state_d;
    logic [TRACK_DEPTH-1:0] hit1, hit2, pend;
    logic                   busy;
    logic                   hazard;
    logic                   go;
    logic                   issue;
    inflight_t              ins;

    assign ins = '{vld: issue, rd: bus.id_rd, we: bus.id_rd_we, ld: bus.id_is_load};

    pipe_inflight_track #(.RA_W(RA_W)) u_track (
        .clk    (clk),
        .reset  (reset),
        .ins_i  (ins),
        .rs1_i  (bus.id_rs1),
        .rs2_i  (bus.id_rs2),
        .hit1_o (hit1),
        .hit2_o (hit2),
        .pend_o (pend),
        .busy_o (busy)
    );

    // Only a load sitting in EX can stall: its value appears after MEM.
    assign hazard = bus.id_valid & pend[STG_EX] &
                    ((bus.id_rs1_used & hit1[STG_EX]) | (bus.id_rs2_used & hit2[STG_EX]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        go      = 1'b0;
        issue   = 1'b0;
        case (state_q)
            RUN: begin
                if (bus.halt_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!busy) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                if (!bus.halt_req) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase
        // halt_req outranks a load-use hazard; reset forces everything idle.
        go    = !reset && (state_q == RUN) && !bus.halt_req && !hazard;
        issue = go && bus.id_valid;
    end

    assign bus.pc_en       = go;
    assign bus.ifid_en     = go;
    assign bus.issue       = issue;
    assign bus.idex_bubble = !issue;
    assign bus.halted      = (state_q == HALTED);
    assign bus.fwd_sel_a   = fwd_pick(bus.id_rs1_used, hit1, pend);
    assign bus.fwd_sel_b   = fwd_pick(bus.id_rs2_used, hit2, pend);

`ifdef HAZ_PERF_CNT_EN
    logic        stall_inc;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign stall_inc = hazard && (state_q == RUN) && !bus.halt_req;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_inc && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= 16'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
`else
    assign bus.stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Table-driven, cycle-by-cycle bench for pipe_hazard_ctrl with an expected-value queue.
module tb_pipe_hazard_ctrl;

`ifdef HAZ_PERF_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    typedef struct {
        string      nm;
        logic       r;
        logic       v;
        logic [1:0] rs1;
        logic       u1;
        logic [1:0] rs2;
        logic       u2;
        logic [1:0] rd;
        logic       we;
        logic       ld;
        logic       h;
        logic       pc;
        logic       iss;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       fchk;
        logic       hl;
        int         st;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t tbl[$];
    vec_t exp_q[$];

    pipe_hazard_ctrl_if #(.RA_W(2)) bus ();

    pipe_hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string nm, logic r, logic v, logic [1:0] rs1, logic u1,
                                logic [1:0] rs2, logic u2, logic [1:0] rd, logic we, logic ld,
                                logic h, logic pc, logic iss, logic [1:0] fa, logic [1:0] fb,
                                logic fchk, logic hl, int st);
        vec_t t;
        t.nm = nm; t.r = r; t.v = v; t.rs1 = rs1; t.u1 = u1; t.rs2 = rs2; t.u2 = u2;
        t.rd = rd; t.we = we; t.ld = ld; t.h = h; t.pc = pc; t.iss = iss;
        t.fa = fa; t.fb = fb; t.fchk = fchk; t.hl = hl; t.st = st;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic check_out();
        vec_t e;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: no expected entry queued");
            return;
        end
        e = exp_q.pop_front();
        chk({e.nm, ".pc_en"},       16'(bus.pc_en),       16'(e.pc));
        chk({e.nm, ".ifid_en"},     16'(bus.ifid_en),     16'(e.pc));
        chk({e.nm, ".issue"},       16'(bus.issue),       16'(e.iss));
        chk({e.nm, ".idex_bubble"}, 16'(bus.idex_bubble), 16'(!e.iss));
        chk({e.nm, ".halted"},      16'(bus.halted),      16'(e.hl));
        chk({e.nm, ".stall_cnt"},   bus.stall_cnt,        CNT_ON ? 16'(e.st) : 16'd0);
        if (e.fchk) begin
            chk({e.nm, ".fwd_sel_a"}, 16'(bus.fwd_sel_a), 16'(e.fa));
            chk({e.nm, ".fwd_sel_b"}, 16'(bus.fwd_sel_b), 16'(e.fb));
        end
        $display("[TB] %-12s pc_en=%0d issue=%0d fa=%0d fb=%0d halted=%0d stall=%0d",
                 e.nm, bus.pc_en, bus.issue, bus.fwd_sel_a, bus.fwd_sel_b, bus.halted,
                 bus.stall_cnt);
    endtask

    // One vector = one clock: drive at negedge, sample just before the next posedge.
    task automatic run_vec(input vec_t t);
        @(negedge clk);
        reset           = t.r;
        bus.id_valid    = t.v;
        bus.id_rs1      = t.rs1;
        bus.id_rs1_used = t.u1;
        bus.id_rs2      = t.rs2;
        bus.id_rs2_used = t.u2;
        bus.id_rd       = t.rd;
        bus.id_rd_we    = t.we;
        bus.id_is_load  = t.ld;
        bus.halt_req    = t.h;
        exp_q.push_back(t);
        #4;
        check_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs1_used = 0; bus.id_rs2 = 0;
        bus.id_rs2_used = 0; bus.id_rd = 0; bus.id_rd_we = 0; bus.id_is_load = 0;
        bus.halt_req = 0;

        //                nm           r  v  rs1 u1 rs2 u2 rd  we ld h   pc is fa fb fc hl st
        // reset and idle
        tbl.push_back(mk("rst",        1, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk("idle",       0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0, 0));
        // EX -> MEM -> WB -> RF forwarding walk
        tbl.push_back(mk("add_rd1",    0, 1, 0, 0, 0, 0, 1, 1, 0, 0,   1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk("sub_ex",     0, 1, 1, 1, 0, 0, 2, 1, 0, 0,   1, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk("sub_mem",    0, 1, 1, 1, 0, 0, 2, 1, 0, 0,   1, 1, 2, 0, 1, 0, 0));
        tbl.push_back(mk("sub_wb",     0, 1, 1, 1, 0, 0, 2, 1, 0, 0,   1, 1, 3, 0, 1, 0, 0));
        tbl.push_back(mk("sub_rf",     0, 1, 1, 1, 0, 0, 2, 1, 0, 0,   1, 1, 0, 0, 1, 0, 0));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk("flush_a",0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0, 0));
        // load-use: one bubble, then forward from MEM
        tbl.push_back(mk("load_rd1",   0, 1, 0, 0, 0, 0, 1, 1, 1, 0,   1, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk("ldu_stall",  0, 1, 0, 0, 1, 1, 2, 1, 0, 0,   0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk("ldu_issue",  0, 1, 0, 0, 1, 1, 2, 1, 0, 0,   1, 1, 0, 2, 1, 0, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk("flush_b",0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0, 1));
        // priority: rd2 in EX and MEM, rd3 in WB
        tbl.push_back(mk("p_rd3",      0, 1, 0, 0, 0, 0, 3, 1, 0, 0,   1, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk("p_rd2",      0, 1, 0, 0, 0, 0, 2, 1, 0, 0,   1, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk("p_rd2",      0, 1, 0, 0, 0, 0, 2, 1, 0, 0,   1, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk("prio_ab",    0, 1, 2, 1, 3, 1, 0, 0, 0, 0,   1, 1, 1, 3, 1, 0, 1));
        tbl.push_back(mk("p_rd3",      0, 1, 0, 0, 0, 0, 3, 1, 0, 0,   1, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk("p_rd2",      0, 1, 0, 0, 0, 0, 2, 1, 0, 0,   1, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk("p_rd2",      0, 1, 0, 0, 0, 0, 2, 1, 0, 0,   1, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk("prio_nouse", 0, 1, 2, 0, 3, 1, 0, 0, 0, 0,   1, 1, 0, 3, 1, 0, 1));
        tbl.push_back(mk("p_rd3",      0, 1, 0, 0, 0, 0, 3, 1, 0, 0,   1, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk("p_rd2",      0, 1, 0, 0, 0, 0, 2, 1, 0, 0,   1, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk("p_rd2_nowe", 0, 1, 0, 0, 0, 0, 2, 0, 0, 0,   1, 1, 0, 0, 1, 0, 1));
        tbl.push_back(mk("prio_exnowe",0, 1, 2, 1, 3, 1, 0, 0, 0, 0,   1, 1, 2, 3, 1, 0, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk("flush_c",0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0, 1));

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i]);

        // drain with three in flight, halt, resume; held instruction issues
        run_vec(mk("h_a",          0, 1, 0, 0, 0, 0, 1, 1, 0, 0,   1, 1, 0, 0, 1, 0, 1));
        run_vec(mk("h_b",          0, 1, 0, 0, 0, 0, 2, 1, 0, 0,   1, 1, 0, 0, 1, 0, 1));
        run_vec(mk("h_c",          0, 1, 0, 0, 0, 0, 3, 1, 0, 0,   1, 1, 0, 0, 1, 0, 1));
        run_vec(mk("halt_req",     0, 1, 1, 1, 0, 0, 0, 0, 0, 1,   0, 0, 3, 0, 1, 0, 1));
        run_vec(mk("drain1",       0, 1, 1, 1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 1));
        run_vec(mk("drain2",       0, 1, 1, 1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 1));
        run_vec(mk("drain3",       0, 1, 1, 1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 1));
        run_vec(mk("halted",       0, 1, 1, 1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 1, 1));
        run_vec(mk("halt_drop",    0, 1, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1, 1));
        run_vec(mk("resume",       0, 1, 1, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 1));

        // halt wins over load-use hazard (no stall count); halt dropped mid-drain
        run_vec(mk("hz_load",      0, 1, 0, 0, 0, 0, 1, 1, 1, 0,   1, 1, 0, 0, 1, 0, 1));
        run_vec(mk("hz_halt",      0, 1, 1, 1, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1));
        run_vec(mk("hz_drain1",    0, 1, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 2, 0, 1, 0, 1));
        run_vec(mk("hz_drain2",    0, 1, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 3, 0, 1, 0, 1));
        run_vec(mk("hz_drain3",    0, 1, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 0, 1));
        run_vec(mk("hz_halted",    0, 1, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 1, 1));
        run_vec(mk("hz_resume",    0, 1, 1, 1, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 1));

        // reset pulse mid-drain with two valid entries
        run_vec(mk("r_rd1",        0, 1, 0, 0, 0, 0, 1, 1, 0, 0,   1, 1, 0, 0, 1, 0, 1));
        run_vec(mk("r_rd2",        0, 1, 0, 0, 0, 0, 2, 1, 0, 0,   1, 1, 0, 0, 1, 0, 1));
        run_vec(mk("r_halt",       0, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 1));
        run_vec(mk("r_pulse",      1, 0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1, 0, 0));
        run_vec(mk("r_after",      0, 1, 1, 1, 2, 1, 0, 0, 0, 0,   1, 1, 0, 0, 1, 0, 0));

        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: %0d expected entries left unchecked", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
